// File: rtl/brisc_pkg.sv
// brisc_pkg: shared opcode encoding, instruction field positions, the fetch
// sequencer state encoding and default datapath widths for the BRISC core.
package brisc_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;

    // Same encoding the control decoder uses.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_LDI  = 4'd10;
    localparam logic [3:0] OP_MOV  = 4'd11;
    localparam logic [3:0] OP_IN   = 4'd12;
    localparam logic [3:0] OP_OUT  = 4'd13;
    localparam logic [3:0] OP_JZ   = 4'd14;
    localparam logic [3:0] OP_J    = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } seq_state_e;

    // Extract the opcode field from a full instruction word.
    function automatic logic [3:0] opcode_of(input logic [DEF_INSTR_W-1:0] w);
        return w[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction ROM port plus the opcode/jump_en link to
// the combinational control decoder. master = sequencer, slave = ROM/decoder.
interface fetch_sequencer_if
    import brisc_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_rdata;
    logic               jump_en;
    logic [3:0]         opcode;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;

    modport master (
        output imem_addr, imem_rd_en, opcode, instr, instr_valid,
        input  imem_rdata, jump_en
    );

    modport slave (
        input  imem_addr, imem_rd_en, opcode, instr, instr_valid,
        output imem_rdata, jump_en
    );
endinterface

// File: rtl/fetch_sequencer_pc_unit.sv
// pc_unit: program counter (load / increment / hold, wrapping modulo
// 2^ADDR_W) and the retired-instruction counter. Both move only on advance.
module pc_unit #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired
);

    // Step the PC and count the retirement at the end of each issue cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            retired <= '0;
        end else if (advance) begin
            pc      <= load ? target : pc + ADDR_W'(1);
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: BRISC fetch/issue sequencer. Walks IDLE -> FETCH -> WAIT
// -> ISSUE, three cycles per instruction, and picks the next PC from the
// decoder's jump_en during ISSUE.
// Optional macro FETCH_SINGLE_STEP_EN adds a 'step' pulse input that runs
// exactly one instruction from IDLE while run is low.
module fetch_sequencer
    import brisc_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic               step,
`endif
    fetch_sequencer_if.master  bus,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   retired,
    output logic               busy
);

    seq_state_e         state, state_nx;
    logic [INSTR_W-1:0] instr_q;
    logic               start;

`ifdef FETCH_SINGLE_STEP_EN
    // step only matters in IDLE; once busy, the FSM never looks at it, so
    // stray pulses are dropped rather than queued.
    assign start = run | step;
`else
    assign start = run;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; run is re-checked only at the end of ISSUE so an
    // instruction already in flight always completes.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   state_nx = WAIT;
            WAIT:    state_nx = ISSUE;
            ISSUE:   state_nx = run ? FETCH : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Latch the ROM word returned during WAIT; held through ISSUE and beyond.
    always_ff @(posedge clk) begin
        if (rst)               instr_q <= '0;
        else if (state == WAIT) instr_q <= bus.imem_rdata;
    end

    // ROM address always tracks pc; the strobe marks the single FETCH cycle.
    assign bus.imem_addr   = pc;
    assign bus.imem_rd_en  = (state == FETCH);
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state == ISSUE);
    // NOP outside ISSUE keeps the decoder from raising any write or jump.
    assign bus.opcode      = (state == ISSUE) ? opcode_of(instr_q) : OP_NOP;
    assign busy            = (state != IDLE);

    pc_unit #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_pc_unit (
        .clk     (clk),
        .rst     (rst),
        .advance (state == ISSUE),
        .load    (bus.jump_en),
        .target  (instr_q[ADDR_W-1:0]),
        .pc      (pc),
        .retired (retired)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench. A reference walk of the ROM pushes
// the expected (opcode, pc, instr) per issue; every instr_valid pulse pops
// and compares. Per-scenario tasks check reset, jumps, wrap, run drop, reset
// mid-fetch and (with FETCH_SINGLE_STEP_EN) single-stepping.
module tb_fetch_sequencer;
    import brisc_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [3:0]         op;
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic run;
`ifdef FETCH_SINGLE_STEP_EN
    logic step;
`endif
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  retired;
    logic              busy;
    logic              force_jump;

    logic [INSTR_W-1:0] rom [0:255];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    exp_t             sb[$];
    int               vcyc[$];
    logic [ADDR_W-1:0] rlog[$];

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
`ifdef FETCH_SINGLE_STEP_EN
        .step    (step),
`endif
        .bus     (bus),
        .pc      (pc),
        .retired (retired),
        .busy    (busy)
    );

    // Synchronous ROM: one cycle read latency.
    always @(posedge clk)
        if (bus.imem_rd_en) bus.imem_rdata <= rom[bus.imem_addr];

    // Decoder model; force_jump injects jump_en outside ISSUE.
    assign bus.jump_en = (bus.opcode == OP_J) | force_jump;

    // One cycle: sample at negedge, score any issue, log ROM reads.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.instr_valid === 1'b1) begin
            vcyc.push_back(cyc);
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL issue_unexpected: cycle %0d opcode %h pc %h, no issue expected", cyc, bus.opcode, pc);
            end else begin
                e = sb.pop_front();
                if (bus.opcode !== e.op || pc !== e.pc || bus.instr !== e.instr) begin
                    fails++;
                    $display("FAIL issue: cycle %0d op/pc/instr got %h/%h/%h expected %h/%h/%h",
                             cyc, bus.opcode, pc, bus.instr, e.op, e.pc, e.instr);
                end
            end
        end
        if (bus.imem_rd_en === 1'b1) rlog.push_back(bus.imem_addr);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; force_jump = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (2) tick();
        rst = 1'b0;
        sb.delete(); vcyc.delete(); rlog.delete();
        cyc = 0;
    endtask

    // Reference walk of the program: push expected issues, return final pc.
    task automatic model(input int n, input logic [ADDR_W-1:0] start, output logic [ADDR_W-1:0] endp);
        logic [ADDR_W-1:0]  p;
        logic [INSTR_W-1:0] w;
        exp_t e;
        p = start;
        for (int i = 0; i < n; i++) begin
            w = rom[p];
            e.op = w[15:12]; e.pc = p; e.instr = w;
            sb.push_back(e);
            p = (w[15:12] == OP_J) ? w[ADDR_W-1:0] : p + 8'd1;
        end
        endp = p;
    endtask

    // Run n instructions, dropping run in the WAIT cycle of the last one.
    // Outside ISSUE cycles jump_en is forced high; it must have no effect.
    task automatic run_prog(input int n);
        run = 1'b1;
        for (int c = 1; c <= 3 * n; c++) begin
            tick();
            force_jump = (cyc % 3 != 0);
            if (c == 3 * n - 1) run = 1'b0;
        end
        force_jump = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rst = 1'b1; run = 1'b1; force_jump = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (3) begin
            tick();
            tests++;
            if (busy !== 1'b0 || bus.imem_rd_en !== 1'b0) begin
                fails++;
                $display("FAIL reset_wins: busy %b rd_en %b, required 0/0", busy, bus.imem_rd_en);
            end
        end
        tests++;
        if (pc !== 8'd0 || retired !== 16'd0 || bus.instr !== 16'd0 || bus.opcode !== 4'd0 ||
            bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'd0) begin
            fails++;
            $display("FAIL reset_values: pc %h ret %h instr %h op %h vld %b addr %h, required all 0",
                     pc, retired, bus.instr, bus.opcode, bus.instr_valid, bus.imem_addr);
        end
        rst = 1'b0;   // run still high: FETCH on the very next cycle
        tick();
        tests++;
        if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 8'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL first_fetch: rd_en %b addr %h busy %b, required 1/00/1", bus.imem_rd_en, bus.imem_addr, busy);
        end
        do_reset();
    endtask

    task automatic test_basic_jump();
        logic [ADDR_W-1:0] endp;
        do_reset();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1123; rom[1] = 16'h3123; rom[2] = 16'hF005;
        rom[3] = 16'h4777; rom[5] = 16'h2456;
        model(4, 8'd0, endp);
        run_prog(4);
        tick();
        tests++;
        if (vcyc.size() != 4 || vcyc[0] != 3 || vcyc[1] != 6) begin
            fails++;
            $display("FAIL issue_timing: %0d pulses, first at %0d/%0d, required 4 pulses at 3/6",
                     vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1, (vcyc.size() > 1) ? vcyc[1] : -1);
        end
        tests++;
        if (retired !== 16'd4 || pc !== endp || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_end: retired %0d pc %h busy %b, required 4 %h 0", retired, pc, busy, endp);
        end
        tests++;
        if (rlog.size() != 4 || rlog[3] !== 8'd5 || rlog[2] !== 8'd2) begin
            fails++;
            $display("FAIL jump_fetch: %0d reads, read[3] %h, required 4 reads with read[3]=05",
                     rlog.size(), (rlog.size() > 3) ? rlog[3] : 8'hxx);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL basic_sb: %0d issues missing, required 0", sb.size());
        end
    endtask

    task automatic test_run_drop();
        logic [ADDR_W-1:0] endp;
        int nreads;
        do_reset();
        for (int i = 0; i < 256; i++) rom[i] = 16'h6000 | 16'(i);
        model(2, 8'd0, endp);
        run_prog(2);
        nreads = rlog.size();
        repeat (6) begin
            tick();
            tests++;
            if (busy !== 1'b0 || bus.opcode !== 4'd0 || bus.instr_valid !== 1'b0 || rlog.size() != nreads) begin
                fails++;
                $display("FAIL run_drop_idle: busy %b op %h vld %b reads %0d, required 0 0 0 %0d",
                         busy, bus.opcode, bus.instr_valid, rlog.size(), nreads);
            end
        end
        tests++;
        if (vcyc.size() != 2 || pc !== endp || retired !== 16'd2) begin
            fails++;
            $display("FAIL run_drop_count: pulses %0d pc %h retired %0d, required 2 %h 2", vcyc.size(), pc, retired, endp);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] endp;
        do_reset();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0A00 | 16'(i);
        model(258, 8'd0, endp);
        run_prog(258);
        tick();
        tests++;
        if (retired !== 16'd258 || pc !== endp || pc !== 8'd2) begin
            fails++;
            $display("FAIL wrap_end: retired %0d pc %h, required 258 02", retired, pc);
        end
        tests++;
        if (rlog.size() != 258 || rlog[255] !== 8'hFF || rlog[256] !== 8'h00 || $isunknown(rlog[256])) begin
            fails++;
            $display("FAIL wrap_addr: reads %0d, read[256] %h, required 258 reads with read[256]=00",
                     rlog.size(), (rlog.size() > 256) ? rlog[256] : 8'hxx);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL wrap_sb: %0d issues missing, required 0", sb.size());
        end
    endtask

    task automatic test_rst_in_wait();
        logic [ADDR_W-1:0] endp;
        do_reset();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1111; rom[1] = 16'h3222; rom[2] = 16'h5333;
        model(2, 8'd0, endp);
        run = 1'b1;
        for (int c = 1; c <= 8; c++) tick();
        tests++;
        if (pc !== 8'd2 || retired !== 16'd2 || bus.instr !== 16'h3222) begin
            fails++;
            $display("FAIL pre_reset: pc %h retired %0d instr %h, required 02 2 3222", pc, retired, bus.instr);
        end
        rst = 1'b1;   // cycle 8 is the WAIT of the third instruction
        tick();
        tests++;
        if (pc !== 8'd0 || bus.instr !== 16'd0 || bus.opcode !== 4'd0 || bus.instr_valid !== 1'b0 ||
            retired !== 16'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait: pc %h instr %h op %h vld %b ret %0d busy %b, required all 0",
                     pc, bus.instr, bus.opcode, bus.instr_valid, retired, busy);
        end
        rst = 1'b0; run = 1'b0;
        repeat (4) tick();
        tests++;
        if (busy !== 1'b0 || sb.size() != 0 || vcyc.size() != 2) begin
            fails++;
            $display("FAIL rst_wait_after: busy %b pending %0d pulses %0d, required 0 0 2", busy, sb.size(), vcyc.size());
        end
    endtask

`ifdef FETCH_SINGLE_STEP_EN
    task automatic test_single_step();
        logic [ADDR_W-1:0] endp;
        do_reset();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1001; rom[1] = 16'h2002; rom[2] = 16'h3003; rom[3] = 16'h4004;
        model(3, 8'd0, endp);
        run = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL step_idle: step %0d busy %b, required 0", s, busy);
            end
            step = 1'b1;
            tick();
            step = 1'b1;   // seen in FETCH only: must be ignored
            tick();
            step = 1'b0;
            repeat (8) tick();
        end
        tests++;
        if (vcyc.size() != 3 || pc !== endp || retired !== 16'd3 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_step: pulses %0d pc %h retired %0d busy %b, required 3 %h 3 0",
                     vcyc.size(), pc, retired, busy, endp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_jump();
        test_run_drop();
        test_wrap();
        test_rst_in_wait();
`ifdef FETCH_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
